// File: rtl/tlc_param_controller.sv
// Parameterised multi-phase traffic-light controller with demand-skipping,
// green extension on continued demand, and a maintenance flashing mode.
module tlc_param_controller #(
   parameter int unsigned NPH     = 4,
   parameter int unsigned TW      = 8,
   parameter int unsigned GP_T    = 30,
   parameter int unsigned GO_T    = 15,
   parameter int unsigned Y_T     = 3,
   parameter int unsigned R_T     = 2,
   parameter int unsigned EXT_T   = 5,
   parameter int unsigned FLASH_T = 1,
   parameter int unsigned MAX_EXT = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    ena,
   input  logic                    peak,
   input  logic                    flash,
   input  logic [NPH-1:0]          sensor,
   output logic [2*NPH-1:0]        TL,
   output logic [$clog2(NPH)-1:0]  cur_phase,
   output logic                    phase_start
);

   localparam int unsigned PW = $clog2(NPH);
   localparam int unsigned EW = (MAX_EXT > 0) ? $clog2(MAX_EXT + 1) : 1;

   typedef enum logic [1:0] {S_ALLRED, S_GREEN, S_YELLOW, S_FLASH} state_e;

   state_e            state_q, state_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic [PW-1:0]     cur_q, cur_d;
   logic [NPH-1:0]    demand_q, demand_d;
   logic [EW-1:0]     ext_q, ext_d;
   logic              peak_l_q, peak_l_d;
   logic              blink_q, blink_d;
   logic              ps_q, ps_d;
   logic [PW-1:0]     nxt;

   // Phase 0 always qualifies, so the search cannot come up empty.
   function automatic logic [PW-1:0] next_phase(input logic [PW-1:0] cur,
                                                input logic pk,
                                                input logic [NPH-1:0] dm);
      logic [PW-1:0] res;
      logic          found;
      int unsigned   p;
      res   = '0;
      found = 1'b0;
      for (int unsigned k = 1; k <= NPH; k++) begin
         p = (32'(cur) + k) % NPH;
         if (!found && (p == 0 || pk || dm[PW'(p)])) begin
            res   = PW'(p);
            found = 1'b1;
         end
      end
      return res;
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_ALLRED;
         timer_q  <= TW'(R_T);
         cur_q    <= PW'(NPH - 1);
         demand_q <= '0;
         ext_q    <= '0;
         peak_l_q <= 1'b0;
         blink_q  <= 1'b1;
         ps_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         cur_q    <= cur_d;
         demand_q <= demand_d;
         ext_q    <= ext_d;
         peak_l_q <= peak_l_d;
         blink_q  <= blink_d;
         ps_q     <= ps_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      cur_d    = cur_q;
      ext_d    = ext_q;
      peak_l_d = peak_l_q;
      blink_d  = blink_q;
      ps_d     = 1'b0;
      demand_d = demand_q | sensor;
      nxt      = next_phase(cur_q, peak_l_q, demand_q);

      if (flash) begin
         if (state_q != S_FLASH) begin
            state_d = S_FLASH;
            timer_d = TW'(FLASH_T);
            blink_d = 1'b1;
         end else if (ena) begin
            if (timer_q > TW'(1)) begin
               timer_d = timer_q - 1'b1;
            end else begin
               timer_d = TW'(FLASH_T);
               blink_d = ~blink_q;
            end
         end
      end else if (state_q == S_FLASH) begin
         // Parking on the last phase makes phase 0 the next one served.
         state_d = S_ALLRED;
         timer_d = TW'(R_T);
         cur_d   = PW'(NPH - 1);
      end else if (ena) begin
         if (timer_q > TW'(1)) begin
            timer_d = timer_q - 1'b1;
         end else begin
            unique case (state_q)
               S_ALLRED: begin
                  state_d       = S_GREEN;
                  cur_d         = nxt;
                  peak_l_d      = peak;
                  timer_d       = peak ? TW'(GP_T) : TW'(GO_T);
                  ext_d         = '0;
                  demand_d[nxt] = 1'b0;
                  ps_d          = 1'b1;
               end
               S_GREEN: begin
                  if (!peak_l_q && sensor[cur_q] && ext_q < EW'(MAX_EXT)) begin
                     timer_d = TW'(EXT_T);
                     ext_d   = ext_q + 1'b1;
                  end else begin
                     state_d = S_YELLOW;
                     timer_d = TW'(Y_T);
                  end
               end
               S_YELLOW: begin
                  state_d = S_ALLRED;
                  timer_d = TW'(R_T);
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      TL = '0;
      unique case (state_q)
         S_GREEN: begin
            for (int unsigned p = 0; p < NPH; p++)
               if (PW'(p) == cur_q) TL[2*p +: 2] = 2'b10;
         end
         S_YELLOW: begin
            for (int unsigned p = 0; p < NPH; p++)
               if (PW'(p) == cur_q) TL[2*p +: 2] = 2'b01;
         end
         S_FLASH: TL = blink_q ? {NPH{2'b01}} : '1;
         default: ;
      endcase
   end

   assign cur_phase   = cur_q;
   assign phase_start = ps_q;

endmodule

// File: tb/tb_tlc_param_controller.sv
// Scoreboard bench for tlc_param_controller (NPH=4, default timings): expected
// per-cycle lamp/phase/pulse values are queued with the stimulus and popped each cycle.
module tb_tlc_param_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ena = 1'b1;
   logic       peak = 1'b0;
   logic       flash = 1'b0;
   logic [3:0] sensor = '0;
   logic [7:0] TL;
   logic [1:0] cur_phase;
   logic       phase_start;

   int vectors = 0;
   int errors  = 0;

   typedef struct {
      logic [7:0] tl;
      logic [1:0] cp;
      logic       ps;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   tlc_param_controller #(
      .NPH(4), .TW(8), .GP_T(30), .GO_T(15), .Y_T(3), .R_T(2),
      .EXT_T(5), .FLASH_T(1), .MAX_EXT(3)
   ) dut (
      .clk(clk), .reset(reset), .ena(ena), .peak(peak), .flash(flash),
      .sensor(sensor), .TL(TL), .cur_phase(cur_phase), .phase_start(phase_start)
   );

   function automatic logic [7:0] lamp(input int p, input logic [1:0] code);
      logic [7:0] v;
      v = '0;
      v[2*p +: 2] = code;
      return v;
   endfunction

   task automatic push_seg(input logic [7:0] tl, input logic [1:0] cp, input int n, input logic ps0);
      for (int k = 0; k < n; k++) sb.push_back('{tl: tl, cp: cp, ps: (k == 0) ? ps0 : 1'b0});
   endtask

   task automatic push_phase(input int p, input int g);
      push_seg(lamp(p, 2'b10), 2'(p), g, 1'b1);
      push_seg(lamp(p, 2'b01), 2'(p), 3, 1'b0);
      push_seg(8'h00, 2'(p), 2, 1'b0);
   endtask

   task automatic do_reset(input logic pk, input logic [3:0] sn);
      @(negedge clk);
      reset = 1'b0; peak = pk; sensor = sn; flash = 1'b0; ena = 1'b1;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      #1 reset = 1'b0;
      @(negedge clk);
      vectors++;
      if (TL !== 8'h00) begin errors++; $display("FAIL reset_tl: got %h want 00", TL); end
      vectors++;
      if (cur_phase !== 2'd3) begin errors++; $display("FAIL reset_cur: got %0d want 3", cur_phase); end
      vectors++;
      if (phase_start !== 1'b0) begin errors++; $display("FAIL reset_ps: got %b want 0", phase_start); end
   endtask

   task automatic test_peak_cycle();
      exp_t e;
      do_reset(1'b1, 4'b0000);
      push_seg(8'h00, 2'd3, 1, 1'b0);
      for (int p = 0; p < 4; p++) push_phase(p, 30);
      push_seg(lamp(0, 2'b10), 2'd0, 1, 1'b1);
      for (int i = 0; sb.size() > 0; i++) begin
         @(negedge clk);
         e = sb.pop_front();
         vectors++;
         if (TL !== e.tl || cur_phase !== e.cp || phase_start !== e.ps) begin
            errors++;
            $display("FAIL peak_cycle[%0d]: got TL=%h cur=%0d ps=%b want TL=%h cur=%0d ps=%b",
                     i, TL, cur_phase, phase_start, e.tl, e.cp, e.ps);
         end
      end
   endtask

   task automatic test_offpeak_idle();
      exp_t e;
      do_reset(1'b0, 4'b0000);
      push_seg(8'h00, 2'd3, 1, 1'b0);
      push_phase(0, 15);
      push_phase(0, 15);
      push_seg(lamp(0, 2'b10), 2'd0, 1, 1'b1);
      for (int i = 0; sb.size() > 0; i++) begin
         @(negedge clk);
         e = sb.pop_front();
         vectors++;
         if (TL !== e.tl || cur_phase !== e.cp || phase_start !== e.ps) begin
            errors++;
            $display("FAIL offpeak_idle[%0d]: got TL=%h cur=%0d ps=%b want TL=%h cur=%0d ps=%b",
                     i, TL, cur_phase, phase_start, e.tl, e.cp, e.ps);
         end
      end
   endtask

   task automatic test_demand_skip();
      exp_t e;
      do_reset(1'b0, 4'b0000);
      push_seg(8'h00, 2'd3, 1, 1'b0);
      push_phase(0, 15);
      push_phase(2, 15);
      push_seg(lamp(0, 2'b10), 2'd0, 1, 1'b1);
      for (int i = 0; sb.size() > 0; i++) begin
         @(negedge clk);
         e = sb.pop_front();
         vectors++;
         if (TL !== e.tl || cur_phase !== e.cp || phase_start !== e.ps) begin
            errors++;
            $display("FAIL demand_skip[%0d]: got TL=%h cur=%0d ps=%b want TL=%h cur=%0d ps=%b",
                     i, TL, cur_phase, phase_start, e.tl, e.cp, e.ps);
         end
         sensor = (i == 5) ? 4'b0100 : 4'b0000;
      end
   endtask

   task automatic test_extension();
      exp_t e;
      do_reset(1'b0, 4'b0001);
      push_seg(8'h00, 2'd3, 1, 1'b0);
      push_phase(0, 15 + 3 * 5);
      push_seg(lamp(0, 2'b10), 2'd0, 1, 1'b1);
      for (int i = 0; sb.size() > 0; i++) begin
         @(negedge clk);
         e = sb.pop_front();
         vectors++;
         if (TL !== e.tl || cur_phase !== e.cp || phase_start !== e.ps) begin
            errors++;
            $display("FAIL extension[%0d]: got TL=%h cur=%0d ps=%b want TL=%h cur=%0d ps=%b",
                     i, TL, cur_phase, phase_start, e.tl, e.cp, e.ps);
         end
      end
      sensor = 4'b0000;
   endtask

   task automatic test_flash();
      exp_t e;
      do_reset(1'b0, 4'b0000);
      push_seg(8'h00, 2'd3, 1, 1'b0);
      push_seg(lamp(0, 2'b10), 2'd0, 5, 1'b1);
      for (int k = 0; k < 3; k++) begin
         push_seg(8'h55, 2'd0, 1, 1'b0);
         push_seg(8'hFF, 2'd0, 1, 1'b0);
      end
      push_seg(8'h00, 2'd3, 2, 1'b0);
      push_seg(lamp(0, 2'b10), 2'd0, 1, 1'b1);
      for (int i = 0; sb.size() > 0; i++) begin
         @(negedge clk);
         e = sb.pop_front();
         vectors++;
         if (TL !== e.tl || cur_phase !== e.cp || phase_start !== e.ps) begin
            errors++;
            $display("FAIL flash[%0d]: got TL=%h cur=%0d ps=%b want TL=%h cur=%0d ps=%b",
                     i, TL, cur_phase, phase_start, e.tl, e.cp, e.ps);
         end
         if (i == 5) flash = 1'b1;
         if (i == 11) flash = 1'b0;
      end
   endtask

   task automatic test_reset_mid_yellow();
      exp_t e;
      do_reset(1'b0, 4'b0000);
      push_seg(8'h00, 2'd3, 1, 1'b0);
      push_phase(0, 15);
      push_seg(lamp(1, 2'b10), 2'd1, 15, 1'b1);
      push_seg(lamp(1, 2'b01), 2'd1, 2, 1'b0);
      for (int i = 0; sb.size() > 0; i++) begin
         @(negedge clk);
         e = sb.pop_front();
         vectors++;
         if (TL !== e.tl || cur_phase !== e.cp || phase_start !== e.ps) begin
            errors++;
            $display("FAIL mid_reset_pre[%0d]: got TL=%h cur=%0d ps=%b want TL=%h cur=%0d ps=%b",
                     i, TL, cur_phase, phase_start, e.tl, e.cp, e.ps);
         end
         sensor = (i == 3) ? 4'b0010 : 4'b0000;
      end
      #2 reset = 1'b0;
      #1;
      vectors++;
      if (TL !== 8'h00) begin errors++; $display("FAIL mid_reset_tl: got %h want 00", TL); end
      vectors++;
      if (cur_phase !== 2'd3) begin errors++; $display("FAIL mid_reset_cur: got %0d want 3", cur_phase); end
      @(negedge clk);
      reset = 1'b1;
      push_seg(8'h00, 2'd3, 1, 1'b0);
      push_seg(lamp(0, 2'b10), 2'd0, 1, 1'b1);
      for (int i = 0; sb.size() > 0; i++) begin
         @(negedge clk);
         e = sb.pop_front();
         vectors++;
         if (TL !== e.tl || cur_phase !== e.cp || phase_start !== e.ps) begin
            errors++;
            $display("FAIL mid_reset_post[%0d]: got TL=%h cur=%0d ps=%b want TL=%h cur=%0d ps=%b",
                     i, TL, cur_phase, phase_start, e.tl, e.cp, e.ps);
         end
      end
   endtask

   task automatic test_ena_hold();
      exp_t e;
      do_reset(1'b0, 4'b0000);
      push_seg(8'h00, 2'd3, 1, 1'b0);
      push_phase(0, 15 + 10);
      push_seg(lamp(0, 2'b10), 2'd0, 1, 1'b1);
      for (int i = 0; sb.size() > 0; i++) begin
         @(negedge clk);
         e = sb.pop_front();
         vectors++;
         if (TL !== e.tl || cur_phase !== e.cp || phase_start !== e.ps) begin
            errors++;
            $display("FAIL ena_hold[%0d]: got TL=%h cur=%0d ps=%b want TL=%h cur=%0d ps=%b",
                     i, TL, cur_phase, phase_start, e.tl, e.cp, e.ps);
         end
         if (i == 4) ena = 1'b0;
         if (i == 14) ena = 1'b1;
      end
   endtask

   initial begin
      test_reset();
      test_peak_cycle();
      test_offpeak_idle();
      test_demand_skip();
      test_extension();
      test_flash();
      test_reset_mid_yellow();
      test_ena_hold();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/tlc_param_controller.md
TLC_PARAM_CONTROLLER -- requirements
Module: tlc_param_controller

Interface
REQ-001 The block SHALL have parameter NPH, default 4, number of signal phases (2..8).
REQ-002 The block SHALL have parameter TW, default 8, timer width in bits; every duration parameter SHALL fit in TW bits and be >= 1.
REQ-003 The block SHALL have duration parameters GP_T=30, GO_T=15, Y_T=3, R_T=2, EXT_T=5 and FLASH_T=1, each counted in ena ticks: peak green, off-peak green, yellow, all-red, green extension step and flash half-period.
REQ-004 The block SHALL have parameter MAX_EXT, default 3, the maximum number of green extensions per phase.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port ena, input, 1 bit: time-base tick; timers advance only in cycles where ena=1.
REQ-008 The block SHALL have port peak, input, 1 bit: 1 = peak period; driven by the existing peak/off-peak detector.
REQ-009 The block SHALL have port flash, input, 1 bit: maintenance flashing-mode request, level-sensitive.
REQ-010 The block SHALL have port sensor, input, NPH bits: per-phase vehicle-demand inputs.
REQ-011 The block SHALL have port TL, output, 2*NPH bits: per-phase light, where TL[2p+1:2p] is phase p, encoded 00 red, 01 yellow, 10 green, 11 dark.
REQ-012 The block SHALL have port cur_phase, output, clog2(NPH) bits: index of the phase currently served.
REQ-013 The block SHALL have port phase_start, output, 1 bit: one-cycle pulse in the first cycle of any green.

Function
REQ-014 States SHALL be ALLRED, GREEN, YELLOW and FLASH; in ALLRED all TL=00; in GREEN/YELLOW phase cur_phase is 10/01 and all others 00.
REQ-015 Timer SHALL load the state duration on state entry; in a cycle with ena=1 it SHALL decrement if >1, else expire and transition that cycle; with ena tied high each state lasts exactly its duration in clk cycles.
REQ-016 With ena=0, state, timer, extension count and outputs SHALL hold; demand latching SHALL continue.
REQ-017 Transitions: GREEN->YELLOW (Y_T), YELLOW->ALLRED (R_T), ALLRED->GREEN of the next served phase; cur_phase updates on ALLRED exit.
REQ-018 Next served phase SHALL be the first p, searching cur_phase+1 upward modulo NPH, with p==0 or peak_l==1 or demand[p]==1; phase 0 is always served, so the search always terminates.
REQ-019 peak SHALL be latched into peak_l on GREEN entry; green duration SHALL be GP_T if peak_l=1, else GO_T; a mid-green peak change SHALL not affect the current green.
REQ-020 demand[p] SHALL set in any cycle sensor[p]=1 and clear in the cycle phase p enters GREEN; clear SHALL win over a simultaneous set.
REQ-021 Green extension: at GREEN expiry with peak_l=0, sensor[cur_phase]=1 and ext_cnt<MAX_EXT, the timer SHALL reload EXT_T and ext_cnt SHALL increment instead of leaving GREEN; ext_cnt clears on GREEN entry.
REQ-022 flash=1 SHALL force FLASH on the next clock edge from any state, taking priority over all transitions.
REQ-023 In FLASH, every TL field SHALL be 01 while blink=1 and 11 while blink=0; blink SHALL be 1 on entry and toggle every FLASH_T ena ticks.
REQ-024 flash=0 while in FLASH SHALL enter ALLRED with R_T and cur_phase=NPH-1, so that phase 0 is served next.
REQ-025 phase_start SHALL be registered and asserted only in the first GREEN cycle; it SHALL not be asserted on an extension reload.

Reset
REQ-026 reset=0 SHALL immediately set state=ALLRED, timer=R_T, cur_phase=NPH-1, demand=0, ext_cnt=0, peak_l=0, blink=1, phase_start=0, and all TL=00.
REQ-027 Reset asserted mid-operation SHALL abort the current phase without passing through yellow; after release the first green SHALL be phase 0.

Verification (NPH=4, defaults, ena=1 unless stated)
REQ-028 Bench SHALL cover: release reset, peak=1, sensor=0 -> 2 cycles all red, then phase 0 green 30, yellow 3, red 2, then phases 1, 2, 3 in turn, then wrap to 0.
REQ-029 Bench SHALL cover: peak=0, sensor=0 -> phase 0 green 15, yellow 3, red 2, then phase 0 green again with phase_start pulsing; phases 1..3 are never green.
REQ-030 Bench SHALL cover: peak=0, one-cycle pulse on sensor[2] during phase 0 green -> next green is phase 2 with cur_phase=2, phases 1 and 3 are skipped, and demand[2] is clear afterwards.
REQ-031 Bench SHALL cover: peak=0, sensor[0] held high -> phase 0 green lasts exactly 15+3*5=30 cycles, then yellow.
REQ-032 Bench SHALL cover: flash=1 mid-green -> next cycle all TL=01, then TL alternates 11/01 every cycle; flash=0 -> 2 cycles all red, then phase 0 green.
REQ-033 Bench SHALL cover: reset pulsed low mid-yellow between clock edges -> TL=00 before the next edge; ena=0 for 10 cycles mid-green -> green extended by exactly 10 cycles.
